// File: rtl/kf8237_transfer_sequencer_pkg.sv
// Shared types and constants for the 8237 transfer sequencer: state encoding,
// transfer mode/type codes and the one-hot to channel-number helper.
package kf8237_transfer_sequencer_pkg;

  typedef enum logic [2:0] {
    SEQ_SI = 3'd0,
    SEQ_S0 = 3'd1,
    SEQ_S1 = 3'd2,
    SEQ_S2 = 3'd3,
    SEQ_S3 = 3'd4,
    SEQ_SW = 3'd5,
    SEQ_S4 = 3'd6
  } seq_state_t;

  localparam logic [1:0] MODE_DEMAND  = 2'd0;
  localparam logic [1:0] MODE_SINGLE  = 2'd1;
  localparam logic [1:0] MODE_BLOCK   = 2'd2;
  localparam logic [1:0] MODE_CASCADE = 2'd3;

  localparam logic [1:0] TYPE_VERIFY  = 2'd0;
  localparam logic [1:0] TYPE_WRITE   = 2'd1;
  localparam logic [1:0] TYPE_READ    = 2'd2;
  localparam logic [1:0] TYPE_ILLEGAL = 2'd3;

  function automatic logic [1:0] bit2num(input logic [3:0] one_hot);
    logic [1:0] num;
    case (one_hot)
      4'b0001: num = 2'd0;
      4'b0010: num = 2'd1;
      4'b0100: num = 2'd2;
      4'b1000: num = 2'd3;
      default: num = 2'd0;
    endcase
    return num;
  endfunction

endpackage

// File: rtl/kf8237_upper_address_tracker.sv
// Holds the upper address byte strobed out in S1 and reports whether the
// current address has moved to a different 256-byte page since then.
module kf8237_upper_address_tracker (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_master_clear,
  input  logic       i_capture,
  input  logic       i_invalidate,
  input  logic [7:0] i_address_upper,
  output logic [7:0] o_address_upper,
  output logic       o_changed
);

  logic [7:0] r_upper;
  logic       r_valid;

  // Latch the upper byte at the end of S1; an abort or end of service forgets it.
  always_ff @(negedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_upper <= 8'h00;
      r_valid <= 1'b0;
    end else if (i_master_clear) begin
      r_upper <= 8'h00;
      r_valid <= 1'b0;
    end else if (i_invalidate) begin
      r_valid <= 1'b0;
    end else if (i_capture) begin
      r_upper <= i_address_upper;
      r_valid <= 1'b1;
    end
  end

  // During S1 the external latch sees the live byte while ADSTB is high.
  assign o_address_upper = i_capture ? i_address_upper : r_upper;
  assign o_changed       = !r_valid || (i_address_upper != r_upper);

endmodule

// File: rtl/kf8237_transfer_sequencer.sv
// 8237 transfer timing FSM (SI/S0/S1/S2/S3/SW/S4) with HRQ/HLDA handshake and bus strobes.
// Optional macro KF8237_COMPRESSED_TIMING_EN adds the compressed_timing input (S3 skipped).
module kf8237_transfer_sequencer
  import kf8237_transfer_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        master_clear,
  input  logic [3:0]  dma_request_granted,
  input  logic [1:0]  transfer_mode,
  input  logic [1:0]  transfer_type,
  input  logic        autoinitialize,
  input  logic        hold_acknowledge,
  input  logic        ready,
  input  logic        end_of_process_in,
  input  logic [15:0] transfer_address,
  input  logic        underflow,
`ifdef KF8237_COMPRESSED_TIMING_EN
  input  logic        compressed_timing,
`endif
  output logic        hold_request,
  output logic [3:0]  dma_acknowledge_internal,
  output logic        next_word,
  output logic        initialize_current_register,
  output logic        address_enable,
  output logic        address_strobe,
  output logic [7:0]  address_low,
  output logic [7:0]  address_upper,
  output logic        io_read_n,
  output logic        io_write_n,
  output logic        memory_read_n,
  output logic        memory_write_n,
  output logic        terminal_count
);

  seq_state_t r_state;
  seq_state_t w_next_state;
  seq_state_t w_continue_state;

  logic       r_cascade;
  logic [1:0] r_mode;
  logic [1:0] r_type;
  logic       r_autoinit;
  logic [3:0] r_dack;
  logic       r_hold_request;
  logic       r_address_enable;
  logic       r_address_strobe;
  logic       r_io_read_n;
  logic       r_io_write_n;
  logic       r_memory_read_n;
  logic       r_memory_write_n;

  logic       w_compressed;
  logic       w_latch_grant;
  logic       w_enter_cascade;
  logic       w_next_word;
  logic       w_terminal_count;
  logic       w_initialize;
  logic       w_changed;
  logic       w_grant_match;
  logic       w_terminate;
  logic       w_read_phase;
  logic       w_write_phase;
  logic       w_io_read_n;
  logic       w_io_write_n;
  logic       w_memory_read_n;
  logic       w_memory_write_n;

`ifdef KF8237_COMPRESSED_TIMING_EN
  assign w_compressed = compressed_timing;
`else
  assign w_compressed = 1'b0;
`endif

  assign w_terminate      = underflow | end_of_process_in;
  assign w_grant_match    = (dma_request_granted != 4'b0000) &&
                            (bit2num(dma_request_granted) == bit2num(r_dack));
  assign w_continue_state = w_changed ? SEQ_S1 : SEQ_S2;

  kf8237_upper_address_tracker u_upper_address_tracker (
    .i_clock         (clock),
    .i_reset_n       (reset),
    .i_master_clear  (master_clear),
    .i_capture       (r_state == SEQ_S1),
    .i_invalidate    (w_next_state == SEQ_SI),
    .i_address_upper (transfer_address[15:8]),
    .o_address_upper (address_upper),
    .o_changed       (w_changed)
  );

  // State register.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= SEQ_SI;
    end else if (master_clear) begin
      r_state <= SEQ_SI;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus the per-cycle advance/TC/autoinit pulses.
  always_comb begin
    w_next_state     = r_state;
    w_latch_grant    = 1'b0;
    w_enter_cascade  = 1'b0;
    w_next_word      = 1'b0;
    w_terminal_count = 1'b0;
    w_initialize     = 1'b0;
    case (r_state)
      SEQ_SI: begin
        if (dma_request_granted != 4'b0000) w_next_state = SEQ_S0;
        else                                w_next_state = SEQ_SI;
      end
      SEQ_S0: begin
        if (r_cascade) begin
          if (dma_request_granted == 4'b0000) w_next_state = SEQ_SI;
          else                                w_next_state = SEQ_S0;
        end else if (hold_acknowledge) begin
          if (dma_request_granted != 4'b0000) begin
            w_latch_grant = 1'b1;
            if (transfer_mode == MODE_CASCADE) begin
              w_enter_cascade = 1'b1;
              w_next_state    = SEQ_S0;
            end else begin
              w_next_state = SEQ_S1;
            end
          end else begin
            w_next_state = SEQ_SI;
          end
        end else begin
          w_next_state = SEQ_S0;
        end
      end
      SEQ_S1: begin
        if (!hold_acknowledge) w_next_state = SEQ_SI;
        else                   w_next_state = SEQ_S2;
      end
      SEQ_S2: begin
        if (!hold_acknowledge) begin
          w_next_state = SEQ_SI;
        end else if (w_compressed) begin
          if (ready) begin
            w_next_word  = 1'b1;
            w_next_state = SEQ_S4;
          end else begin
            w_next_state = SEQ_SW;
          end
        end else begin
          w_next_state = SEQ_S3;
        end
      end
      SEQ_S3, SEQ_SW: begin
        if (!hold_acknowledge) begin
          w_next_state = SEQ_SI;
        end else if (ready) begin
          w_next_word  = 1'b1;
          w_next_state = SEQ_S4;
        end else begin
          w_next_state = SEQ_SW;
        end
      end
      SEQ_S4: begin
        if (!hold_acknowledge) begin
          w_next_state = SEQ_SI;
        end else if (w_terminate) begin
          w_terminal_count = 1'b1;
          w_initialize     = r_autoinit;
          w_next_state     = SEQ_SI;
        end else begin
          case (r_mode)
            MODE_SINGLE: w_next_state = SEQ_SI;
            MODE_BLOCK:  w_next_state = w_continue_state;
            MODE_DEMAND: begin
              if (w_grant_match) w_next_state = w_continue_state;
              else               w_next_state = SEQ_SI;
            end
            default:     w_next_state = SEQ_SI;
          endcase
        end
      end
      default: w_next_state = SEQ_SI;
    endcase
  end

  // Strobe levels for the state being entered, so the registered strobes line up with it.
  always_comb begin
    w_read_phase     = (w_next_state == SEQ_S2) || (w_next_state == SEQ_S3) ||
                       (w_next_state == SEQ_SW);
    w_write_phase    = (w_next_state == SEQ_S3) || (w_next_state == SEQ_SW) ||
                       ((w_next_state == SEQ_S2) && w_compressed);
    w_io_read_n      = 1'b1;
    w_io_write_n     = 1'b1;
    w_memory_read_n  = 1'b1;
    w_memory_write_n = 1'b1;
    case (r_type)
      TYPE_WRITE: begin
        w_io_read_n      = !w_read_phase;
        w_memory_write_n = !w_write_phase;
      end
      TYPE_READ: begin
        w_memory_read_n  = !w_read_phase;
        w_io_write_n     = !w_write_phase;
      end
      TYPE_VERIFY, TYPE_ILLEGAL: begin
        w_io_read_n      = 1'b1;
        w_memory_write_n = 1'b1;
      end
      default: begin
        w_io_read_n      = 1'b1;
        w_memory_write_n = 1'b1;
      end
    endcase
  end

  // Registered bus outputs and the per-service latched channel attributes.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      r_hold_request   <= 1'b0;
      r_dack           <= 4'b0000;
      r_cascade        <= 1'b0;
      r_mode           <= 2'd0;
      r_type           <= 2'd0;
      r_autoinit       <= 1'b0;
      r_address_enable <= 1'b0;
      r_address_strobe <= 1'b0;
      r_io_read_n      <= 1'b1;
      r_io_write_n     <= 1'b1;
      r_memory_read_n  <= 1'b1;
      r_memory_write_n <= 1'b1;
    end else if (master_clear) begin
      r_hold_request   <= 1'b0;
      r_dack           <= 4'b0000;
      r_cascade        <= 1'b0;
      r_mode           <= 2'd0;
      r_type           <= 2'd0;
      r_autoinit       <= 1'b0;
      r_address_enable <= 1'b0;
      r_address_strobe <= 1'b0;
      r_io_read_n      <= 1'b1;
      r_io_write_n     <= 1'b1;
      r_memory_read_n  <= 1'b1;
      r_memory_write_n <= 1'b1;
    end else begin
      r_hold_request <= (w_next_state != SEQ_SI);
      if (w_next_state == SEQ_SI) begin
        r_dack <= 4'b0000;
      end else if (w_latch_grant) begin
        r_dack <= dma_request_granted;
      end
      if (w_latch_grant) begin
        r_mode     <= transfer_mode;
        r_type     <= transfer_type;
        r_autoinit <= autoinitialize;
      end
      r_cascade        <= (w_next_state != SEQ_SI) && (r_cascade || w_enter_cascade);
      r_address_enable <= (w_next_state != SEQ_SI) && (w_next_state != SEQ_S0);
      r_address_strobe <= (w_next_state == SEQ_S1);
      r_io_read_n      <= w_io_read_n;
      r_io_write_n     <= w_io_write_n;
      r_memory_read_n  <= w_memory_read_n;
      r_memory_write_n <= w_memory_write_n;
    end
  end

  assign hold_request                = r_hold_request;
  assign dma_acknowledge_internal    = r_dack;
  assign next_word                   = w_next_word;
  assign initialize_current_register = w_initialize;
  assign terminal_count              = w_terminal_count;
  assign address_enable              = r_address_enable;
  assign address_strobe              = r_address_strobe;
  assign address_low                 = r_address_enable ? transfer_address[7:0] : 8'h00;
  assign io_read_n                   = r_io_read_n;
  assign io_write_n                  = r_io_write_n;
  assign memory_read_n               = r_memory_read_n;
  assign memory_write_n              = r_memory_write_n;

endmodule
